im_frame_writer: RTL and testbench

- Capture-side counterpart of the image display path: accepts a streamed 227x227 RGB frame and writes it into the three per-colour image BRAM write ports (port A).
- The display path reads these BRAMs on port B.
- Selects one of three image banks so the displayed image set (im_st 0..2) can be reloaded at runtime.
- Sits between the upstream pixel source (UART/DMA unpacker) and the blk_mem_gen instances.

---
 rtl/im_frame_writer_if.sv | 28 ++
 rtl/im_frame_writer.sv | 122 ++++++++++++
 tb/tb_im_frame_writer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/im_frame_writer_if.sv
// Pixel stream in, per-bank BRAM port-A writes out.
// master drives the pixel stream and observes the writes; slave is the frame writer.
`timescale 1ns/1ps
interface im_frame_writer_if #(
  parameter int ADDR_W = 16
) ();
  logic              pix_valid;
  logic              pix_sof;
  logic [7:0]        pix_r;
  logic [7:0]        pix_g;
  logic [7:0]        pix_b;
  logic              pix_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_r;
  logic [7:0]        wr_g;
  logic [7:0]        wr_b;
  logic [2:0]        wr_we;

  modport master (
    output pix_valid, pix_sof, pix_r, pix_g, pix_b,
    input  pix_ready, wr_addr, wr_r, wr_g, wr_b, wr_we
  );

  modport slave (
    input  pix_valid, pix_sof, pix_r, pix_g, pix_b,
    output pix_ready, wr_addr, wr_r, wr_g, wr_b, wr_we
  );
endinterface

// File: rtl/im_frame_writer.sv
// Writes one streamed H_IM x V_IM RGB frame into the selected image bank; writes appear one cycle after
// the accepted beat, pix_ready is high only while armed. Optional checksum under IM_WRITER_CKSUM_EN.
`timescale 1ns/1ps
module im_frame_writer #(
  parameter int H_IM   = 227,
  parameter int V_IM   = 227,
  parameter int ADDR_W = 16
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        bank_in,
  im_frame_writer_if.slave  pix,
  output logic              busy,
  output logic              done,
  output logic              sof_err,
  output logic [15:0]       cksum
);

  localparam int unsigned       NPIX = H_IM * V_IM;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        bank_q, bank_d;
  logic              err_q, err_d;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr;

  assign pix.pix_ready = (state_q == WAIT_SOF) || (state_q == WRITE);
  assign accept        = pix.pix_valid && pix.pix_ready;
  assign busy          = pix.pix_ready;
  assign done          = (state_q == DONE);
  assign sof_err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    waddr   = cnt_q;
    if (start) begin
      // start re-arms from any state; a beat in the same cycle is dropped
      state_d = WAIT_SOF;
      cnt_d   = '0;
      err_d   = 1'b0;
      bank_d  = (bank_in == 2'd3) ? 2'd0 : bank_in;
    end else if (accept) begin
      if (pix.pix_sof) begin
        waddr = '0;
        wr_en = 1'b1;
        if (state_q == WRITE && cnt_q != '0) err_d = 1'b1;
      end else if (state_q == WRITE) begin
        waddr = cnt_q;
        wr_en = 1'b1;
      end
      if (wr_en) begin
        if (waddr == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          state_d = WRITE;
          cnt_d   = waddr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= 2'd0;
      err_q       <= 1'b0;
      pix.wr_we   <= 3'b000;
      pix.wr_addr <= '0;
      pix.wr_r    <= 8'd0;
      pix.wr_g    <= 8'd0;
      pix.wr_b    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      err_q     <= err_d;
      pix.wr_we <= wr_en ? (3'b001 << bank_q) : 3'b000;
      // address and data hold between writes
      if (wr_en) begin
        pix.wr_addr <= waddr;
        pix.wr_r    <= pix.pix_r;
        pix.wr_g    <= pix.pix_g;
        pix.wr_b    <= pix.pix_b;
      end
    end
  end

`ifdef IM_WRITER_CKSUM_EN
  logic [15:0] cksum_q;
  logic [15:0] beat_sum;

  assign beat_sum = 16'(pix.pix_r) + 16'(pix.pix_g) + 16'(pix.pix_b);

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      cksum_q <= 16'd0;
    end else if (start) begin
      cksum_q <= 16'd0;
    end else if (wr_en) begin
      // an SOF beat begins a fresh frame sum
      cksum_q <= (pix.pix_sof ? 16'd0 : cksum_q) + beat_sum;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = 16'd0;
`endif

endmodule

// File: tb/tb_im_frame_writer.sv
// Bench for im_frame_writer: directed vector table, full-frame, random-gap and reset sequences
// checked cycle by cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_im_frame_writer;

  localparam int H  = 227;
  localparam int V  = 227;
  localparam int N  = H * V;
  localparam int AW = 16;

  logic        video_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  bank_in;
  logic        busy;
  logic        done;
  logic        sof_err;
  logic [15:0] cksum;

  im_frame_writer_if #(.ADDR_W(AW)) pif ();

  im_frame_writer #(.H_IM(H), .V_IM(V), .ADDR_W(AW)) dut (
    .video_clk (video_clk),
    .rst       (rst),
    .start     (start),
    .bank_in   (bank_in),
    .pix       (pif),
    .busy      (busy),
    .done      (done),
    .sof_err   (sof_err),
    .cksum     (cksum)
  );

  always #5 video_clk = ~video_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
    end
  endtask

  // Reference model: frame position (-1 = waiting for SOF) and expected write port
  bit          m_armed, m_done, m_err;
  int          m_pos;
  logic [1:0]  m_bank;
  int unsigned m_sum;
  logic [2:0]  e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_r, e_g, e_b;
  int          n_wr_model, n_wr_seen;
  logic        last_rdy;

  function automatic void model_reset();
    m_armed = 0; m_done = 0; m_err = 0; m_pos = -1; m_bank = 2'd0; m_sum = 0;
    e_we = 3'b000; e_addr = 16'd0; e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
  endfunction

  function automatic logic [15:0] e_cksum();
`ifdef IM_WRITER_CKSUM_EN
    return 16'(m_sum);
`else
    return 16'd0;
`endif
  endfunction

  // Called just after a falling edge: drive, check ready, clock, check outputs
  task automatic step(input logic st, input logic [1:0] bk, input logic v, input logic sof,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit wrote;
    int a;
    start = st; bank_in = bk;
    pif.pix_valid = v; pif.pix_sof = sof; pif.pix_r = r; pif.pix_g = g; pif.pix_b = b;
    #1;
    last_rdy = pif.pix_ready;
    chk("pix_ready", {63'd0, pif.pix_ready}, {63'd0, m_armed});
    wrote = 0;
    a = 0;
    if (st) begin
      m_armed = 1; m_pos = -1; m_done = 0; m_err = 0; m_sum = 0;
      m_bank = (bk == 2'd3) ? 2'd0 : bk;
    end else if (v && m_armed) begin
      if (sof) begin
        if (m_pos > 0) m_err = 1;
        m_sum = 0; a = 0; wrote = 1;
      end else if (m_pos >= 0) begin
        a = m_pos; wrote = 1;
      end
    end
    e_we = 3'b000;
    if (wrote) begin
      m_sum += int'(r) + int'(g) + int'(b);
      e_we = 3'(1 << m_bank);
      e_addr = 16'(a); e_r = r; e_g = g; e_b = b;
      n_wr_model++;
      if (a == N - 1) begin
        m_armed = 0; m_done = 1; m_pos = -1;
      end else begin
        m_pos = a + 1;
      end
    end
    @(posedge video_clk);
    @(negedge video_clk);
    if (pif.wr_we != 3'b000) n_wr_seen++;
    chk("outputs",
        {2'b00, pif.wr_we, pif.wr_addr, pif.wr_r, pif.wr_g, pif.wr_b, busy, done, sof_err, cksum},
        {2'b00, e_we, e_addr, e_r, e_g, e_b, m_armed, m_done, m_err, e_cksum()});
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  bk;
    logic        v;
    logic        sof;
    logic [7:0]  d;
    logic        rdy;
    logic [2:0]  we;
    logic [15:0] addr;
    logic        bsy;
    logic        dn;
    logic        er;
  } vec_t;

  function automatic vec_t mk(logic st, logic [1:0] bk, logic v, logic sof, logic [7:0] d,
                              logic rdy, logic [2:0] we, logic [15:0] addr,
                              logic bsy, logic dn, logic er);
    vec_t t;
    t.st = st; t.bk = bk; t.v = v; t.sof = sof; t.d = d;
    t.rdy = rdy; t.we = we; t.addr = addr; t.bsy = bsy; t.dn = dn; t.er = er;
    return t;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [16];
    tbl[0]  = mk(1, 2, 1, 1, 8'h00,  0, 3'b000, 16'd0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 8'h11,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 8'h12,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 8'h13,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 8'h14,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 8'h15,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 8'hAA,  1, 3'b100, 16'd0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 8'h00,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 8'hAB,  1, 3'b100, 16'd1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 8'hAC,  1, 3'b100, 16'd0, 1, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 8'hAD,  1, 3'b100, 16'd1, 1, 0, 1);
    tbl[11] = mk(1, 1, 1, 1, 8'hAE,  1, 3'b000, 16'd1, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, 8'hAF,  1, 3'b010, 16'd0, 1, 0, 0);
    tbl[13] = mk(1, 3, 0, 0, 8'h00,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[14] = mk(0, 0, 1, 0, 8'hB0,  1, 3'b000, 16'd0, 1, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 8'hB1,  1, 3'b001, 16'd0, 1, 0, 0);

    rst = 1'b1; start = 1'b0; bank_in = 2'd0;
    pif.pix_valid = 1'b0; pif.pix_sof = 1'b0; pif.pix_r = 8'd0; pif.pix_g = 8'd0; pif.pix_b = 8'd0;
    model_reset();
    n_wr_model = 0; n_wr_seen = 0;
    #1;
    chk("reset_state",
        {8'd0, pif.pix_ready, pif.wr_we, pif.wr_addr, pif.wr_r, pif.wr_g, pif.wr_b, busy, done, sof_err, cksum},
        64'd0);
    @(negedge video_clk);
    @(negedge video_clk);
    rst = 1'b0;

    // Directed vectors: WAIT_SOF discard, bank select, mid-frame SOF, start abort, bank 3 -> 0
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].bk, tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].d, tbl[i].d);
      chk($sformatf("tbl%0d_rdy", i), {63'd0, last_rdy}, {63'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_we", i), {61'd0, pif.wr_we}, {61'd0, tbl[i].we});
      chk($sformatf("tbl%0d_addr", i), {48'd0, pif.wr_addr}, {48'd0, tbl[i].addr});
      chk($sformatf("tbl%0d_flags", i), {61'd0, busy, done, sof_err},
          {61'd0, tbl[i].bsy, tbl[i].dn, tbl[i].er});
    end

    // Full frame into bank 1 with a restarting SOF at pixel 100, then all-ones pixels
    step(1, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    n_wr_seen = 0;
    for (int i = 0; i < 100; i++) step(0, 0, 1, (i == 0), 8'(i), 8'(i), 8'(i));
    step(0, 0, 1, 1, 8'd1, 8'd1, 8'd1);
    for (int i = 1; i < N; i++) step(0, 0, 1, 0, 8'd1, 8'd1, 8'd1);
    chk("last_addr", {48'd0, pif.wr_addr}, 64'(N - 1));
    chk("last_we", {61'd0, pif.wr_we}, 64'b010);
    step(0, 0, 1, 0, 8'd9, 8'd9, 8'd9);
    chk("frame_writes", 64'(n_wr_seen), 64'(100 + N));
    chk("done_after", {63'd0, done}, 64'd1);
    chk("ready_after", {63'd0, pif.pix_ready}, 64'd0);
    chk("sof_err_after", {63'd0, sof_err}, 64'd1);
`ifdef IM_WRITER_CKSUM_EN
    chk("cksum_frame", {48'd0, cksum}, 64'd23515);
`else
    chk("cksum_frame", {48'd0, cksum}, 64'd0);
`endif
    step(1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    chk("start_clears", {62'd0, done, sof_err}, 64'd0);

    // Random valid gaps with occasional SOF restarts and aborts
    n_wr_seen = 0; n_wr_model = 0;
    for (int k = 0; k < 1500; k++) begin
      logic       st, v, sof;
      logic [1:0] bk;
      st  = ($urandom_range(0, 399) == 0);
      bk  = 2'($urandom_range(0, 3));
      v   = 1'($urandom_range(0, 1));
      sof = (k == 0) || ($urandom_range(0, 299) == 0);
      step(st, bk, v, sof, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    chk("rand_writes", 64'(n_wr_seen), 64'(n_wr_model));

    // Asynchronous reset at pixel 3000
    step(1, 2, 0, 0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3000; i++) step(0, 0, 1, (i == 0), 8'(i), 8'(i + 7), 8'(i + 3));
    start = 1'b0; pif.pix_valid = 1'b1; pif.pix_sof = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset",
        {8'd0, pif.pix_ready, pif.wr_we, pif.wr_addr, pif.wr_r, pif.wr_g, pif.wr_b, busy, done, sof_err, cksum},
        64'd0);
    @(posedge video_clk);
    @(negedge video_clk);
    chk("reset_hold", {61'd0, pif.wr_we}, 64'd0);
    rst = 1'b0;
    model_reset();
    step(1, 3, 0, 0, 8'd0, 8'd0, 8'd0);
    step(0, 0, 1, 1, 8'd55, 8'd66, 8'd77);
    chk("bank3_we", {61'd0, pif.wr_we}, 64'b001);
    chk("bank3_addr", {48'd0, pif.wr_addr}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
